digit_serial_addsub: RTL and testbench

Parametrised, multi-cycle add/subtract unit with an optional accumulator. It processes a WIDTH-bit operation CHUNK bits per clock, ripple-carrying between chunks through a registered carry. It takes operands through a valid/ready handshake and returns sum, carry and signed overflow through a second valid/ready handshake. It is the next-generation arithmetic block behind the Tiny Tapeout top, trading latency for area on wide operands.

---
 rtl/digit_serial_addsub.sv | 156 +++++++++++++++
 tb/tb_digit_serial_addsub.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub
// Brief    : Digit-serial add/subtract unit with optional accumulator; CHUNK
//            bits per cycle, registered inter-chunk carry, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int c_nch = WIDTH / CHUNK;
    localparam int c_kw  = (c_nch > 1) ? $clog2(c_nch) : 1;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_nch - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("digit_serial_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_l;
    logic [WIDTH-1:0] r_r;
    logic             r_carry;
    logic             r_acc_op;
    logic [c_kw-1:0]  r_k;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_src;
    logic [WIDTH-1:0] w_l_sel;
    logic [WIDTH-1:0] w_r_sel;
    logic [CHUNK-1:0] w_l_chunk;
    logic [CHUNK-1:0] w_r_chunk;
    logic [CHUNK:0]   w_chunk_res;
    logic [WIDTH-1:0] w_full;
    logic             w_cin_msb;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_last    = (r_state == S_RUN) && (r_k == c_k_last);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // A clear in the same cycle as an accepted ACC op must feed zero, not
    // the stale accumulator, into the left operand.
    assign w_acc_src = acc_clr ? '0 : r_acc;
    assign w_l_sel   = op[1] ? w_acc_src : a;
    assign w_r_sel   = op[1] ? a : b;

    always_comb begin
        w_l_chunk   = r_l[r_k*CHUNK +: CHUNK];
        w_r_chunk   = r_r[r_k*CHUNK +: CHUNK];
        w_chunk_res = {1'b0, w_l_chunk} + {1'b0, w_r_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_full      = r_sum;
        w_full[r_k*CHUNK +: CHUNK] = w_chunk_res[CHUNK-1:0];
        // Carry into the MSB recovered from the MSB's own half-sum.
        w_cin_msb   = r_l[WIDTH-1] ^ r_r[WIDTH-1] ^ w_full[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l      <= '0;
            r_r      <= '0;
            r_carry  <= 1'b0;
            r_acc_op <= 1'b0;
            r_k      <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (acc_clr) begin
                        r_acc <= '0;
                    end
                    if (w_accept) begin
                        r_l      <= w_l_sel;
                        r_r      <= op[0] ? ~w_r_sel : w_r_sel;
                        r_carry  <= cin ^ op[0];
                        r_acc_op <= op[1];
                        r_k      <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_full;
                    r_carry <= w_chunk_res[CHUNK];
                    if (w_last) begin
                        r_cout <= w_chunk_res[CHUNK];
                        r_ovf  <= w_cin_msb ^ w_chunk_res[CHUNK];
                        if (r_acc_op) begin
                            r_acc <= w_full;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_addsub
// Brief    : Self-checking bench: directed vector table, randomized ops against
//            an arithmetic reference model, backpressure/reset/parameter cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_addsub;

    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, acc_clr, out_valid, out_ready, cout, ovf, busy;
    logic [1:0]  op;
    logic [15:0] a, b, sum;

    digit_serial_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    logic        p_in_valid, p_in_ready, p_out_valid, p_cout, p_ovf, p_busy;
    logic [15:0] p_a, p_b, p_sum;

    digit_serial_addsub #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .cin(1'b0), .op(2'b00), .acc_clr(1'b0),
        .out_valid(p_out_valid), .out_ready(1'b1), .sum(p_sum),
        .cout(p_cout), .ovf(p_ovf), .busy(p_busy)
    );

    logic        q_in_valid, q_in_ready, q_out_valid, q_cout, q_ovf, q_busy;
    logic [31:0] q_a, q_b, q_sum;

    digit_serial_addsub #(.WIDTH(32), .CHUNK(8)) u_dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .a(q_a), .b(q_b), .cin(1'b0), .op(2'b00), .acc_clr(1'b0),
        .out_valid(q_out_valid), .out_ready(1'b1), .sum(q_sum),
        .cout(q_cout), .ovf(q_ovf), .busy(q_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] acc_m;

    typedef struct {
        logic [15:0] a, b;
        logic        cin;
        logic [1:0]  op;
        logic        clr;
        logic [15:0] s;
        logic        c, o;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the selected operands.
    task automatic model(input logic [15:0] l, input logic [15:0] r, input logic ci,
                         input logic sub, output logic [15:0] s, output logic c,
                         output logic o);
        longint t, ts;
        if (sub) begin
            t  = longint'(l) - longint'(r) - longint'(ci);
            ts = longint'($signed(l)) - longint'($signed(r)) - longint'(ci);
            c  = (t >= 0);
        end else begin
            t  = longint'(l) + longint'(r) + longint'(ci);
            ts = longint'($signed(l)) + longint'($signed(r)) + longint'(ci);
            c  = t[16];
        end
        s = t[15:0];
        o = (ts > 32767) || (ts < -32768);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                          input logic [1:0] top, input logic tclr, input logic [15:0] es,
                          input logic ec, input logic eo, input string nm);
        int   lat;
        logic busy_ok;
        a = ta; b = tb; cin = tcin; op = top; acc_clr = tclr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, NCH);
        chk({nm, " busy"}, busy_ok, 1);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, cout, ec);
        chk({nm, " ovf"}, ovf, eo);
        @(posedge clk); #1;
        chk({nm, " in_ready after"}, in_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb, l, r, es;
        logic [1:0]  rop;
        logic        rcin, rclr, ec, eo, flag;
        int          lat;

        vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 2'b00, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{16'h0005, 16'h0007, 1'b0, 2'b01, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 2'b01, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6]  = '{16'h0010, 16'h0001, 1'b1, 2'b01, 1'b0, 16'h000E, 1'b1, 1'b0};
        vecs[7]  = '{16'h0010, 16'hFFFF, 1'b0, 2'b10, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[8]  = '{16'h0010, 16'hFFFF, 1'b0, 2'b10, 1'b0, 16'h0020, 1'b0, 1'b0};
        vecs[9]  = '{16'h0010, 16'hFFFF, 1'b0, 2'b10, 1'b0, 16'h0030, 1'b0, 1'b0};
        vecs[10] = '{16'h0030, 16'h1234, 1'b0, 2'b11, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h0005, 16'hFFFF, 1'b0, 2'b10, 1'b1, 16'h0005, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
        a = '0; b = '0; cin = 1'b0; op = 2'b00;
        p_in_valid = 1'b0; p_a = '0; p_b = '0;
        q_in_valid = 1'b0; q_a = '0; q_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        chk("reset ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clear the accumulator before the ACC rows of the table.
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, vecs[i].clr,
                   vecs[i].s, vecs[i].c, vecs[i].o, $sformatf("vec%0d", i));
        end
        acc_m = 16'h0005;

        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rop  = 2'($urandom_range(0, 3));
            rcin = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 7) == 0);
            if (rclr) acc_m = '0;
            l = rop[1] ? acc_m : ra;
            r = rop[1] ? ra : rb;
            model(l, r, rcin, rop[0], es, ec, eo);
            if (rop[1]) acc_m = es;
            run_op(ra, rb, rcin, rop, rclr, es, ec, eo, $sformatf("rand%0d", i));
        end

        // Backpressure: result held in DONE, in_valid pulses ignored.
        out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", lat, NCH);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'hAAAA;
            @(posedge clk); #1;
            chk("bp out_valid", out_valid, 1);
            chk("bp sum", sum, 16'h3333);
            chk("bp cout", cout, 0);
            chk("bp in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp in_ready after", in_ready, 1);
        chk("bp out_valid after", out_valid, 0);
        @(posedge clk); #1;
        chk("bp no queued op", busy, 0);

        // Reset two cycles into RUN of an ACC op with a non-zero accumulator.
        run_op(16'h1234, 16'h0000, 1'b0, 2'b10, 1'b1, 16'h1234, 1'b0, 1'b0, "acc preload");
        a = 16'h0100; op = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 1);
        chk("abort busy", busy, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) flag = 1'b1;
        end
        chk("abort no stale out_valid", flag, 0);
        run_op(16'h0001, 16'h0000, 1'b0, 2'b10, 1'b0, 16'h0001, 1'b0, 1'b0, "acc after reset");

        // CHUNK=WIDTH instance: single-cycle latency.
        p_a = 16'h7FFF; p_b = 16'h0001; p_in_valid = 1'b1;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        lat = 0;
        while (!p_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("c16 latency", lat, 1);
        chk("c16 sum", p_sum, 16'h8000);
        chk("c16 cout", p_cout, 0);
        chk("c16 ovf", p_ovf, 1);

        // WIDTH=32, CHUNK=8 instance.
        q_a = 32'hFFFF_FFFF; q_b = 32'h0000_0001; q_in_valid = 1'b1;
        @(posedge clk); #1;
        q_in_valid = 1'b0;
        lat = 0;
        while (!q_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w32 latency", lat, 4);
        chk("w32 sum", q_sum, 32'h0);
        chk("w32 cout", q_cout, 1);
        chk("w32 ovf", q_ovf, 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
